// File: rtl/bsg_arb_resp_pkg.sv
// Shared helpers for the arbiter response router: width calculations and
// one-hot to index encoding.
package bsg_arb_resp_pkg;

  // Widest grant vector the encoder accepts; callers zero-extend to this.
  localparam int max_inputs_lp = 256;

  function automatic int tag_width(input int inputs);
    return (inputs > 1) ? $clog2(inputs) : 1;
  endfunction

  function automatic int count_width(input int els);
    return $clog2(els + 1);
  endfunction

  // Lowest set bit wins, so a malformed multi-hot grant still maps to one requester.
  function automatic int onehot_to_index(input logic [max_inputs_lp-1:0] v);
    int idx;
    idx = 0;
    for (int i = max_inputs_lp - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bsg_arb_resp_tag_fifo.sv
// In-order register FIFO holding granted requester tags until their responses return.
// Write and read in the same cycle are allowed even when full.
module bsg_arb_resp_tag_fifo
  import bsg_arb_resp_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  input  logic [width_p-1:0]            data_i,
  output logic                          full_o,
  input  logic                          yumi_i,
  output logic [width_p-1:0]            data_o,
  output logic                          empty_o,
  output logic [count_width(els_p)-1:0] count_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = count_width(els_p);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0] count;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (v_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (v_i)    wr_ptr <= ptr_inc(wr_ptr);
      if (yumi_i) rd_ptr <= ptr_inc(rd_ptr);
      if (v_i && !yumi_i)      count <= count + cnt_w_lp'(1);
      else if (yumi_i && !v_i) count <= count - cnt_w_lp'(1);
    end
  end

  assign data_o  = mem[rd_ptr];
  assign full_o  = (count == cnt_w_lp'(els_p));
  assign empty_o = (count == '0);
  assign count_o = count;

endmodule

// File: rtl/bsg_arb_resp_router.sv
// Return-path router: records each grant's requester index and steers
// returning responses, in grant order, back to that requester.
module bsg_arb_resp_router
  import bsg_arb_resp_pkg::*;
#(
  parameter int inputs_p     = 16,
  parameter int els_p        = 4,
  parameter int data_width_p = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [inputs_p-1:0]           grants_i,
  output logic                          ready_o,
  input  logic                          resp_v_i,
  input  logic [data_width_p-1:0]       resp_data_i,
  output logic                          resp_ready_o,
  output logic [inputs_p-1:0]           resp_v_o,
  output logic [data_width_p-1:0]       resp_data_o,
  input  logic [inputs_p-1:0]           resp_ready_i,
  output logic [count_width(els_p)-1:0] count_o,
  output logic                          error_o
);

  localparam int tag_w_lp = tag_width(inputs_p);

  logic                grant_fire, multi_hot, full, empty, enq, deq, error_r;
  logic [tag_w_lp-1:0] grant_tag, head_tag;

  assign grant_fire = |grants_i;
  assign multi_hot  = |(grants_i & (grants_i - inputs_p'(1)));
  assign grant_tag  = tag_w_lp'(onehot_to_index(max_inputs_lp'(grants_i)));

  assign resp_ready_o = !empty & resp_ready_i[head_tag];
  assign deq          = resp_v_i & resp_ready_o;
  // A dequeue in the same cycle frees the head slot, so a grant while full still lands.
  assign enq          = grant_fire & (!full | deq);
  assign ready_o      = !full;
  assign resp_data_o  = resp_data_i;

  always_comb begin
    resp_v_o = '0;
    if (resp_v_i && !empty) resp_v_o[head_tag] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if ((grant_fire & (multi_hot | (full & !deq))) | (resp_v_i & empty)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;

  bsg_arb_resp_tag_fifo #(
    .els_p  (els_p),
    .width_p(tag_w_lp)
  ) u_tag_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (enq),
    .data_i   (grant_tag),
    .full_o   (full),
    .yumi_i   (deq),
    .data_o   (head_tag),
    .empty_o  (empty),
    .count_o  (count_o)
  );

endmodule

// File: tb/tb_bsg_arb_resp_router.sv
// Scenario bench for bsg_arb_resp_router with a tag-queue scoreboard model.
module tb_bsg_arb_resp_router;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [15:0] grants_i = '0;
  logic        ready_o;
  logic        resp_v_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        resp_ready_o;
  logic [15:0] resp_v_o;
  logic [31:0] resp_data_o;
  logic [15:0] resp_ready_i = '0;
  logic [2:0]  count_o;
  logic        error_o;

  int passed = 0;
  int total  = 0;
  int q[$];
  bit m_err = 1'b0;

  bsg_arb_resp_router #(.inputs_p(16), .els_p(4), .data_width_p(32)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .grants_i(grants_i), .ready_o(ready_o),
    .resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .resp_ready_o(resp_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
    .count_o(count_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [15:0] g, input logic rv, input logic [31:0] d,
                       input logic [15:0] rr);
    grants_i = g; resp_v_i = rv; resp_data_i = d; resp_ready_i = rr;
    #1;
  endtask

  // Advance the scoreboard with the current inputs, then take the clock edge.
  task automatic tick();
    int  lo;
    bit  m_deq, m_full;
    if (!reset_n_i) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      m_full = (q.size() == 4);
      m_deq  = resp_v_i && (q.size() > 0) && resp_ready_i[q[0]];
      lo = 0;
      if (grants_i != 0) begin
        for (int i = 15; i >= 0; i--) if (grants_i[i]) lo = i;
        if ((grants_i & (grants_i - 16'd1)) != 0) m_err = 1'b1;
        if (m_full && !m_deq) m_err = 1'b1;
      end
      if (resp_v_i && q.size() == 0) m_err = 1'b1;
      if (m_deq) void'(q.pop_front());
      if (grants_i != 0 && (!m_full || m_deq)) q.push_back(lo);
    end
    @(posedge clk_i); #1;
  endtask

  function automatic logic [15:0] exp_rv();
    if (resp_v_i && q.size() > 0) return 16'(1) << q[0];
    return '0;
  endfunction

  task automatic do_reset();
    reset_n_i = 1'b0;
    drive('0, 1'b0, '0, '0);
    tick();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, 1'b0, '0, 16'hFFFF);
    total++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ready_o); else passed++;
    total++; if (count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else passed++;
    total++; if (resp_v_o !== 16'h0) $display("FAIL reset_resp_v got=%h exp=0", resp_v_o); else passed++;
    total++; if (error_o !== 1'b0) $display("FAIL reset_error got=%0b exp=0", error_o); else passed++;
    total++; if (resp_ready_o !== 1'b0) $display("FAIL reset_resp_ready got=%0b exp=0", resp_ready_o); else passed++;
    tick(); tick();
    total++; if (count_o !== 3'd0) $display("FAIL idle_count got=%0d exp=0", count_o); else passed++;
  endtask

  task automatic test_in_order();
    logic [15:0] g   [3] = '{16'h0004, 16'h0001, 16'h8000};
    logic [31:0] dat [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < 3; i++) begin
      drive(g[i], 1'b0, '0, 16'hFFFF);
      tick();
      total++; if (count_o !== 3'(i + 1)) $display("FAIL order_fill_count got=%0d exp=%0d", count_o, i + 1); else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b1, dat[i], 16'hFFFF);
      total++; if (resp_v_o !== g[i]) $display("FAIL order_resp_v got=%h exp=%h", resp_v_o, g[i]); else passed++;
      total++; if (resp_v_o !== exp_rv()) $display("FAIL order_sb_resp_v got=%h exp=%h", resp_v_o, exp_rv()); else passed++;
      total++; if (resp_data_o !== dat[i]) $display("FAIL order_data got=%h exp=%h", resp_data_o, dat[i]); else passed++;
      total++; if (resp_ready_o !== 1'b1) $display("FAIL order_resp_ready got=%0b exp=1", resp_ready_o); else passed++;
      tick();
      total++; if (count_o !== 3'(2 - i)) $display("FAIL order_drain_count got=%0d exp=%0d", count_o, 2 - i); else passed++;
    end
    total++; if (error_o !== 1'b0) $display("FAIL order_error got=%0b exp=0", error_o); else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(16'(1) << (i + 8), 1'b0, '0, '0);
      tick();
      total++; if (ready_o !== (i < 3)) $display("FAIL full_ready got=%0b exp=%0b", ready_o, i < 3); else passed++;
    end
    drive(16'h0002, 1'b0, '0, '0);
    tick();
    total++; if (error_o !== 1'b1) $display("FAIL full_grant_error got=%0b exp=1", error_o); else passed++;
    total++; if (count_o !== 3'd4) $display("FAIL full_grant_count got=%0d exp=4", count_o); else passed++;
    total++; if (count_o !== 3'(q.size())) $display("FAIL full_sb_count got=%0d exp=%0d", count_o, q.size()); else passed++;
    do_reset();
  endtask

  task automatic test_stall();
    drive(16'h0020, 1'b0, '0, '0); tick();
    drive(16'h0008, 1'b0, '0, '0); tick();
    drive('0, 1'b1, 32'h5555_0005, 16'hFFDF);
    total++; if (resp_v_o !== 16'h0020) $display("FAIL stall_resp_v got=%h exp=0020", resp_v_o); else passed++;
    total++; if (resp_ready_o !== 1'b0) $display("FAIL stall_resp_ready got=%0b exp=0", resp_ready_o); else passed++;
    tick();
    total++; if (count_o !== 3'd2) $display("FAIL stall_count got=%0d exp=2", count_o); else passed++;
    drive('0, 1'b1, 32'h5555_0005, 16'hFFFF);
    total++; if (resp_ready_o !== 1'b1) $display("FAIL release_resp_ready got=%0b exp=1", resp_ready_o); else passed++;
    tick();
    total++; if (count_o !== 3'd1) $display("FAIL release_count got=%0d exp=1", count_o); else passed++;
    drive('0, 1'b1, 32'h3333_0003, 16'hFFFF);
    total++; if (resp_v_o !== 16'h0008) $display("FAIL stall_next_head got=%h exp=0008", resp_v_o); else passed++;
    tick();
    total++; if (count_o !== 3'd0) $display("FAIL stall_drain_count got=%0d exp=0", count_o); else passed++;
    total++; if (error_o !== m_err) $display("FAIL stall_error got=%0b exp=%0b", error_o, m_err); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [15:0] order [4] = '{16'h0004, 16'h0008, 16'h0010, 16'h0200};
    drive(16'h0002, 1'b0, '0, '0); tick();
    drive(16'h0004, 1'b0, '0, '0); tick();
    drive(16'h0008, 1'b0, '0, '0); tick();
    drive(16'h0010, 1'b0, '0, '0); tick();
    total++; if (ready_o !== 1'b0) $display("FAIL simul_full_ready got=%0b exp=0", ready_o); else passed++;
    drive(16'h0200, 1'b1, 32'h1111_0001, 16'hFFFF);
    total++; if (resp_v_o !== 16'h0002) $display("FAIL simul_head got=%h exp=0002", resp_v_o); else passed++;
    total++; if (resp_ready_o !== 1'b1) $display("FAIL simul_resp_ready got=%0b exp=1", resp_ready_o); else passed++;
    tick();
    total++; if (count_o !== 3'd4) $display("FAIL simul_count got=%0d exp=4", count_o); else passed++;
    total++; if (error_o !== 1'b0) $display("FAIL simul_error got=%0b exp=0", error_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive('0, 1'b1, 32'(i), 16'hFFFF);
      total++; if (resp_v_o !== order[i]) $display("FAIL simul_drain got=%h exp=%h", resp_v_o, order[i]); else passed++;
      total++; if (resp_v_o !== exp_rv()) $display("FAIL simul_sb_drain got=%h exp=%h", resp_v_o, exp_rv()); else passed++;
      tick();
    end
    total++; if (count_o !== 3'd0) $display("FAIL simul_drained_count got=%0d exp=0", count_o); else passed++;
    drive(16'h0040, 1'b1, 32'h7777_0007, 16'hFFFF);
    total++; if (resp_ready_o !== 1'b0) $display("FAIL nobypass_resp_ready got=%0b exp=0", resp_ready_o); else passed++;
    total++; if (resp_v_o !== 16'h0) $display("FAIL nobypass_resp_v got=%h exp=0", resp_v_o); else passed++;
    tick();
    total++; if (count_o !== 3'd1) $display("FAIL nobypass_count got=%0d exp=1", count_o); else passed++;
    total++; if (error_o !== 1'b1) $display("FAIL nobypass_error got=%0b exp=1", error_o); else passed++;
    drive('0, 1'b1, 32'h7777_0007, 16'hFFFF);
    total++; if (resp_v_o !== 16'h0040) $display("FAIL nobypass_next_v got=%h exp=0040", resp_v_o); else passed++;
    total++; if (resp_ready_o !== 1'b1) $display("FAIL nobypass_next_ready got=%0b exp=1", resp_ready_o); else passed++;
    tick();
    total++; if (count_o !== 3'd0) $display("FAIL nobypass_final_count got=%0d exp=0", count_o); else passed++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    drive(16'h0001, 1'b0, '0, '0); tick();
    drive(16'h0100, 1'b0, '0, '0); tick();
    drive(16'h0400, 1'b0, '0, '0); tick();
    total++; if (count_o !== 3'd3) $display("FAIL mid_pre_count got=%0d exp=3", count_o); else passed++;
    reset_n_i = 1'b0;
    drive(16'h0800, 1'b1, '0, 16'hFFFF);
    tick();
    reset_n_i = 1'b1;
    drive('0, 1'b0, '0, 16'hFFFF);
    total++; if (count_o !== 3'd0) $display("FAIL mid_count got=%0d exp=0", count_o); else passed++;
    total++; if (ready_o !== 1'b1) $display("FAIL mid_ready got=%0b exp=1", ready_o); else passed++;
    total++; if (error_o !== 1'b0) $display("FAIL mid_error got=%0b exp=0", error_o); else passed++;
    drive('0, 1'b1, 32'hDEAD_BEEF, 16'hFFFF);
    total++; if (resp_ready_o !== 1'b0) $display("FAIL mid_late_ready got=%0b exp=0", resp_ready_o); else passed++;
    tick();
    total++; if (error_o !== 1'b1) $display("FAIL mid_late_error got=%0b exp=1", error_o); else passed++;
    do_reset();
  endtask

  task automatic test_errors();
    drive('0, 1'b1, 32'h0BAD_0BAD, 16'hFFFF);
    total++; if (resp_ready_o !== 1'b0) $display("FAIL empty_resp_ready got=%0b exp=0", resp_ready_o); else passed++;
    total++; if (resp_v_o !== 16'h0) $display("FAIL empty_resp_v got=%h exp=0", resp_v_o); else passed++;
    tick();
    total++; if (error_o !== 1'b1) $display("FAIL empty_error got=%0b exp=1", error_o); else passed++;
    drive('0, 1'b0, '0, 16'hFFFF);
    tick(); tick(); tick();
    total++; if (error_o !== 1'b1) $display("FAIL sticky_error got=%0b exp=1", error_o); else passed++;
    do_reset();
    drive(16'h0011, 1'b0, '0, 16'hFFFF);
    tick();
    total++; if (error_o !== 1'b1) $display("FAIL multihot_error got=%0b exp=1", error_o); else passed++;
    total++; if (count_o !== 3'd1) $display("FAIL multihot_count got=%0d exp=1", count_o); else passed++;
    drive('0, 1'b1, 32'h0000_0011, 16'hFFFF);
    total++; if (resp_v_o !== 16'h0001) $display("FAIL multihot_tag got=%h exp=0001", resp_v_o); else passed++;
    tick();
    total++; if (count_o !== 3'd0) $display("FAIL multihot_drain got=%0d exp=0", count_o); else passed++;
    total++; if (error_o !== m_err) $display("FAIL multihot_sb_error got=%0b exp=%0b", error_o, m_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    test_errors();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
